// File: rtl/ysyx_220053_mem_arbiter.sv
// Two-requester arbiter (fetch / data) in front of the single pmem port; one transaction in flight.
// Optional anti-starvation guard for fetch: define YSYX_220053_MEM_ARB_STARVE_GUARD_EN.
module ysyx_220053_mem_arbiter #(
  parameter int AW         = 64,
  parameter int DW         = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  input  logic          i_kill,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [7:0]    d_wmask,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic [7:0]    m_wmask,
  input  logic          m_gnt,
  input  logic          m_rvalid,
  input  logic [DW-1:0] m_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_e;

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic          kill_q, kill_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [7:0]    wmask_q, wmask_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          pick_i;

`ifdef YSYX_220053_MEM_ARB_STARVE_GUARD_EN
  localparam int SCW = ($clog2(STARVE_MAX + 1) < 3) ? 3 : $clog2(STARVE_MAX + 1);
  logic [SCW-1:0] starve_q, starve_d;

  // Fetch overrides data priority once data has won STARVE_MAX times in a row against it.
  assign pick_i = i_req && (!d_req || (starve_q == SCW'(STARVE_MAX)));

  always_comb begin
    starve_d = starve_q;
    if (d_gnt) begin
      starve_d = i_req ? starve_q + SCW'(1) : '0;
    end else if (i_gnt) begin
      starve_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign pick_i = i_req && !d_req;

  if (STARVE_MAX < 0) begin : g_starve_max_unused
  end
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    kill_d  = kill_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    i_gnt   = 1'b0;
    d_gnt   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        kill_d = 1'b0;
        // Grants are gated by rst so every output reads 0 while reset is held.
        if (rst && pick_i) begin
          i_gnt   = 1'b1;
          owner_d = OWN_I;
          kill_d  = i_kill;
          we_d    = 1'b0;
          addr_d  = i_addr;
          wdata_d = '0;
          wmask_d = '0;
          state_d = S_REQ;
        end else if (rst && d_req) begin
          d_gnt   = 1'b1;
          owner_d = OWN_D;
          we_d    = d_we;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          wmask_d = d_wmask;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (owner_q == OWN_I && i_kill) kill_d = 1'b1;
        if (m_gnt) begin
          if (m_rvalid) begin
            rdata_d = we_q ? '0 : m_rdata;
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (owner_q == OWN_I && i_kill) kill_d = 1'b1;
        if (m_rvalid) begin
          rdata_d = we_q ? '0 : m_rdata;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        kill_d  = 1'b0;
        owner_d = OWN_NONE;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      owner_q <= OWN_NONE;
      kill_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      kill_q  <= kill_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
    end
  end

  assign m_req    = (state_q == S_REQ);
  assign m_we     = we_q;
  assign m_addr   = addr_q;
  assign m_wdata  = wdata_q;
  assign m_wmask  = wmask_q;
  assign busy     = (state_q != S_IDLE);
  assign i_rvalid = (state_q == S_RESP) && (owner_q == OWN_I) && !kill_q;
  assign d_rvalid = (state_q == S_RESP) && (owner_q == OWN_D);
  assign i_rdata  = rdata_q;
  assign d_rdata  = rdata_q;

endmodule

// File: tb/tb_ysyx_220053_mem_arbiter.sv
// Directed bench for ysyx_220053_mem_arbiter with a delay-programmable memory responder.
module tb_ysyx_220053_mem_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_kill, i_gnt, i_rvalid;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [7:0]    d_wmask;
  logic          m_req, m_we, m_gnt, m_rvalid, busy;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [7:0]    m_wmask;

  always #5 clk = ~clk;

  ysyx_220053_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wmask(m_wmask), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  // Memory responder: gnt after gnt_dly REQ cycles, rvalid rv_dly cycles after gnt (0 = same cycle).
  int          gnt_dly = 0;
  int          rv_dly  = 0;
  logic [63:0] mem_rdata = '0;

  initial begin
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    forever begin
      @(posedge clk); #1;
      m_gnt = 1'b0; m_rvalid = 1'b0;
      if (m_req) begin
        repeat (gnt_dly) begin @(posedge clk); #1; end
        m_gnt = 1'b1;
        if (rv_dly == 0) begin m_rvalid = 1'b1; m_rdata = mem_rdata; end
        @(posedge clk); #1;
        m_gnt = 1'b0; m_rvalid = 1'b0;
        if (rv_dly > 0) begin
          repeat (rv_dly - 1) begin @(posedge clk); #1; end
          m_rvalid = 1'b1; m_rdata = mem_rdata;
          @(posedge clk); #1;
          m_rvalid = 1'b0;
        end
      end
    end
  end

  int i_gnt_n = 0, d_gnt_n = 0, i_rv_n = 0, d_rv_n = 0;
  always @(negedge clk) begin
    if (i_gnt)    i_gnt_n++;
    if (d_gnt)    d_gnt_n++;
    if (i_rvalid) i_rv_n++;
    if (d_rvalid) d_rv_n++;
  end

  task automatic wait_rv(input bit want_d, input int budget, output logic [63:0] data);
    int   n;
    logic seen;
    n    = 0;
    data = '0;
    seen = want_d ? d_rvalid : i_rvalid;
    while (n < budget && !seen) begin
      tick();
      n++;
      seen = want_d ? d_rvalid : i_rvalid;
    end
    if (seen) data = want_d ? d_rdata : i_rdata;
    else check_eq("rvalid_timeout", {63'b0, seen}, 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [63:0] rd;
  int          c0, c1, c2, c3;
  int          exp_d, exp_i;

  initial begin
    rst = 1'b0; i_req = 0; i_addr = '0; i_kill = 0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wmask = '0;
    tick(); tick();
    d_req = 1'b1; i_req = 1'b1; #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_m_req", m_req, 0);
    check_eq("rst_i_gnt", i_gnt, 0);
    check_eq("rst_d_gnt", d_gnt, 0);
    check_eq("rst_rvalid", {i_rvalid, d_rvalid}, 0);
    check_eq("rst_m_addr", m_addr, 0);
    check_eq("rst_rdata", i_rdata, 0);
    d_req = 1'b0; i_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // Single fetch
    gnt_dly = 1; rv_dly = 2; mem_rdata = 64'h0010_0073;
    i_req = 1'b1; i_addr = 64'h8000_0000; #1;
    check_eq("f1_i_gnt", i_gnt, 1);
    check_eq("f1_d_gnt", d_gnt, 0);
    check_eq("f1_busy_idle", busy, 0);
    tick(); i_req = 1'b0;
    check_eq("f1_m_req_t1", m_req, 1);
    check_eq("f1_m_addr", m_addr, 64'h8000_0000);
    check_eq("f1_m_we", m_we, 0);
    check_eq("f1_m_wmask", m_wmask, 0);
    tick();
    check_eq("f1_m_req_t2", m_req, 1);
    tick();
    check_eq("f1_m_req_wait", m_req, 0);
    check_eq("f1_busy_wait", busy, 1);
    tick();
    check_eq("f1_no_early_rv", i_rvalid, 0);
    tick();
    check_eq("f1_i_rvalid", i_rvalid, 1);
    check_eq("f1_i_rdata", i_rdata, 64'h0010_0073);
    check_eq("f1_d_rvalid", d_rvalid, 0);
    tick();
    check_eq("f1_rv_pulse", i_rvalid, 0);
    check_eq("f1_busy_done", busy, 0);

    // Contention: data wins, fetch granted in first IDLE after data RESP
    gnt_dly = 0; rv_dly = 1; mem_rdata = 64'h1111_2222_3333_4444;
    i_req = 1'b1; i_addr = 64'h8000_0004;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h8000_1000; #1;
    check_eq("ct_d_gnt", d_gnt, 1);
    check_eq("ct_i_gnt_lose", i_gnt, 0);
    tick(); d_req = 1'b0;
    check_eq("ct_m_addr", m_addr, 64'h8000_1000);
    check_eq("ct_i_gnt_req", i_gnt, 0);
    tick();
    check_eq("ct_i_gnt_wait", i_gnt, 0);
    tick();
    check_eq("ct_d_rvalid", d_rvalid, 1);
    check_eq("ct_d_rdata", d_rdata, 64'h1111_2222_3333_4444);
    check_eq("ct_i_gnt_resp", i_gnt, 0);
    tick();
    check_eq("ct_i_gnt_idle", i_gnt, 1);
    check_eq("ct_d_gnt_idle", d_gnt, 0);
    mem_rdata = 64'h13;
    tick(); i_req = 1'b0;
    wait_rv(1'b0, 10, rd);
    check_eq("ct_i_rdata", rd, 64'h13);
    tick();

    // Store at minimum latency
    gnt_dly = 0; rv_dly = 0; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h8000_2000;
    d_wdata = 64'hDEAD_BEEF; d_wmask = 8'h0F; #1;
    check_eq("st_d_gnt", d_gnt, 1);
    tick(); d_req = 1'b0;
    check_eq("st_m_we", m_we, 1);
    check_eq("st_m_wdata", m_wdata, 64'hDEAD_BEEF);
    check_eq("st_m_wmask", m_wmask, 8'h0F);
    check_eq("st_m_addr", m_addr, 64'h8000_2000);
    tick();
    check_eq("st_d_rvalid", d_rvalid, 1);
    check_eq("st_d_rdata_zero", d_rdata, 0);
    tick(); d_we = 1'b0;

    // Load at minimum latency; d_wmask left at 0x0F
    mem_rdata = 64'hCAFE_F00D_0123_4567;
    d_req = 1'b1; d_addr = 64'h8000_3000; #1;
    tick(); d_req = 1'b0;
    tick();
    check_eq("ld_d_rvalid", d_rvalid, 1);
    check_eq("ld_d_rdata", d_rdata, 64'hCAFE_F00D_0123_4567);
    tick();

    // Kill while fetch is in WAIT
    gnt_dly = 0; rv_dly = 3; mem_rdata = 64'hBAD0_BAD0;
    c0 = i_rv_n;
    i_req = 1'b1; i_addr = 64'h8000_0100; #1;
    check_eq("kl_i_gnt", i_gnt, 1);
    tick(); i_req = 1'b0;
    check_eq("kl_m_we_fetch", m_we, 0);
    check_eq("kl_m_wmask_fetch", m_wmask, 0);
    tick(); i_kill = 1'b1;
    check_eq("kl_in_wait", {busy, m_req}, 2'b10);
    tick(); i_kill = 1'b0;
    repeat (6) tick();
    check_eq("kl_no_i_rvalid", i_rv_n - c0, 0);
    check_eq("kl_busy_done", busy, 0);
    rv_dly = 1; mem_rdata = 64'h600D;
    i_req = 1'b1; i_addr = 64'h8000_0104; #1;
    tick(); i_req = 1'b0;
    wait_rv(1'b0, 10, rd);
    check_eq("kl_next_rdata", rd, 64'h600D);
    tick();

    // Kill in the same IDLE cycle as the fetch grant
    mem_rdata = 64'h1234;
    c0 = i_rv_n;
    i_req = 1'b1; i_kill = 1'b1; i_addr = 64'h8000_0108; #1;
    check_eq("kg_i_gnt", i_gnt, 1);
    tick(); i_req = 1'b0; i_kill = 1'b0;
    repeat (5) tick();
    check_eq("kg_no_i_rvalid", i_rv_n - c0, 0);

    // i_kill has no effect on a data transaction
    mem_rdata = 64'h7777;
    d_req = 1'b1; d_addr = 64'h8000_4000; #1;
    tick(); d_req = 1'b0; i_kill = 1'b1;
    wait_rv(1'b1, 10, rd);
    check_eq("kd_d_rdata", rd, 64'h7777);
    i_kill = 1'b0;
    tick();

    // Async reset during WAIT; the late memory response must be ignored
    gnt_dly = 0; rv_dly = 6; mem_rdata = 64'h9999;
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h8000_5000; d_wdata = 64'h55; #1;
    tick(); d_req = 1'b0; d_we = 1'b0;
    tick();
    check_eq("rw_busy_before", busy, 1);
    rst = 1'b0; #1;
    check_eq("rw_busy", busy, 0);
    check_eq("rw_m_req", m_req, 0);
    check_eq("rw_m_we", m_we, 0);
    check_eq("rw_m_addr", m_addr, 0);
    check_eq("rw_m_wdata", m_wdata, 0);
    check_eq("rw_m_wmask", m_wmask, 0);
    check_eq("rw_rvalid", {i_rvalid, d_rvalid}, 0);
    tick(); rst = 1'b1;
    c0 = d_rv_n; c1 = i_rv_n;
    repeat (10) tick();
    check_eq("rw_no_stale_rv", (d_rv_n - c0) + (i_rv_n - c1), 0);
    rv_dly = 1; mem_rdata = 64'hABCD;
    d_req = 1'b1; d_addr = 64'h8000_6000; #1;
    check_eq("rw_d_gnt_after", d_gnt, 1);
    tick(); d_req = 1'b0;
    wait_rv(1'b1, 10, rd);
    check_eq("rw_d_rdata_after", rd, 64'hABCD);
    tick();

    // Both requests held for five service slots
    gnt_dly = 0; rv_dly = 0; mem_rdata = 64'h42;
    c2 = d_gnt_n; c3 = i_gnt_n;
    i_req = 1'b1; d_req = 1'b1; i_addr = 64'h8000_0200; d_addr = 64'h8000_7000;
    repeat (15) tick();
    i_req = 1'b0; d_req = 1'b0;
`ifdef YSYX_220053_MEM_ARB_STARVE_GUARD_EN
    exp_d = 4; exp_i = 1;
`else
    exp_d = 5; exp_i = 0;
`endif
    check_eq("pr_d_grants", d_gnt_n - c2, exp_d);
    check_eq("pr_i_grants", i_gnt_n - c3, exp_i);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
